inc_load_seq: RTL and testbench

- Upstream feeder for the 8-bit loadable counter stage `inc`.
- Accepts 16-bit load words over a valid/ready handshake.
- Drives the counter's `ld`/`data` inputs: low byte first, then (in two-byte mode) the high byte after a programmable gap of idle cycles.
- Pulses `done` when a word has been fully issued, then accepts the next word.

---
 rtl/inc_load_seq.sv | 159 +++++++++++++++
 tb/tb_inc_load_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/inc_load_seq.sv
// -----------------------------------------------------------------------------
// inc_load_seq
//   Upstream feeder for the 8-bit loadable counter stage `inc`. Accepts 16-bit
//   load words over a valid/ready handshake. It issues the low byte on the
//   counter's ld/data pins. In two-byte mode it then waits GAP idle cycles and
//   issues the high byte. A one-cycle `done` pulse marks the end of each word.
//
// Parameters
//   GAP       idle cycles between low-byte and high-byte loads (0..15)
//
// Ports
//   clk       clock, rising edge
//   rst       synchronous active-low reset
//   in_valid  input word/mode valid
//   in_ready  block can accept a word (registered, high only in IDLE)
//   in_word   16-bit load word, [7:0] low byte, [15:8] high byte
//   in_mode   0 = low byte only, 1 = low then high byte
//   ld        one-cycle load strobe to the counter
//   data      load value to the counter, held while ld is low
//   busy      a word is held and not yet completed
//   done      one-cycle pulse when the current word has been fully issued
// -----------------------------------------------------------------------------
module inc_load_seq #(
  parameter int unsigned GAP = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_word,
  input  logic        in_mode,
  output logic        ld,
  output logic [7:0]  data,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LD_LO    = 3'd1;
  localparam logic [2:0] S_GAP_WAIT = 3'd2;
  localparam logic [2:0] S_LD_HI    = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  // The gap counter is loaded with GAP-1 and LD_HI follows the cycle in which
  // it reads zero, giving exactly GAP idle cycles.
  localparam logic       GAP_ZERO = (GAP == 0);
  localparam logic [3:0] GAP_INIT = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  logic [2:0]  state_r;
  logic [3:0]  cnt_r;
  logic [15:0] word_r;
  logic        mode_r;
  logic        in_ready_r;
  logic        ld_r;
  logic [7:0]  data_r;
  logic        busy_r;
  logic        done_r;

  logic        xfer_s;
  logic [2:0]  state_nx_s;
  logic [3:0]  cnt_nx_s;
  logic [15:0] word_nx_s;
  logic        mode_nx_s;
  logic        ld_nx_s;
  logic [7:0]  data_nx_s;

  // Next-state, capture and gap-counter logic.
  always_comb begin
    xfer_s     = in_valid & in_ready_r;
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    word_nx_s  = word_r;
    mode_nx_s  = mode_r;
    case (state_r)
      S_IDLE: begin
        if (xfer_s) begin
          state_nx_s = S_LD_LO;
          word_nx_s  = in_word;
          mode_nx_s  = in_mode;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_LD_LO: begin
        if (!mode_r) begin
          state_nx_s = S_DONE;
        end else if (GAP_ZERO) begin
          state_nx_s = S_LD_HI;
        end else begin
          state_nx_s = S_GAP_WAIT;
          cnt_nx_s   = GAP_INIT;
        end
      end
      S_GAP_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nx_s = S_LD_HI;
        end else begin
          cnt_nx_s = cnt_r - 4'd1;
        end
      end
      S_LD_HI:  state_nx_s = S_DONE;
      S_DONE:   state_nx_s = S_IDLE;
      default:  state_nx_s = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet still
  // line up with the state they describe; data holds whenever ld is low.
  always_comb begin
    ld_nx_s   = 1'b0;
    data_nx_s = data_r;
    case (state_nx_s)
      S_LD_LO: begin
        ld_nx_s   = 1'b1;
        data_nx_s = word_nx_s[7:0];
      end
      S_LD_HI: begin
        ld_nx_s   = 1'b1;
        data_nx_s = word_nx_s[15:8];
      end
      default: begin
        ld_nx_s   = 1'b0;
        data_nx_s = data_r;
      end
    endcase
  end

  // State and registered outputs; reset discards any held word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      cnt_r      <= 4'd0;
      word_r     <= 16'h0000;
      mode_r     <= 1'b0;
      in_ready_r <= 1'b0;
      ld_r       <= 1'b0;
      data_r     <= 8'h00;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      cnt_r      <= cnt_nx_s;
      word_r     <= word_nx_s;
      mode_r     <= mode_nx_s;
      in_ready_r <= (state_nx_s == S_IDLE);
      ld_r       <= ld_nx_s;
      data_r     <= data_nx_s;
      busy_r     <= (state_nx_s != S_IDLE);
      done_r     <= (state_nx_s == S_DONE);
    end
  end

  assign in_ready = in_ready_r;
  assign ld       = ld_r;
  assign data     = data_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_inc_load_seq.sv
module tb_inc_load_seq;

  logic        clk;
  // GAP=2 instance
  logic        rst_a, in_valid_a, in_mode_a, in_ready_a, ld_a, busy_a, done_a;
  logic [15:0] in_word_a;
  logic [7:0]  data_a;
  // GAP=0 instance
  logic        rst_b, in_valid_b, in_mode_b, in_ready_b, ld_b, busy_b, done_b;
  logic [15:0] in_word_b;
  logic [7:0]  data_b;

  int total = 0;
  int bad   = 0;

  inc_load_seq #(.GAP(2)) dut_a (
    .clk(clk), .rst(rst_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_word(in_word_a), .in_mode(in_mode_a), .ld(ld_a), .data(data_a),
    .busy(busy_a), .done(done_a)
  );

  inc_load_seq #(.GAP(0)) dut_b (
    .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_word(in_word_b), .in_mode(in_mode_b), .ld(ld_b), .data(data_b),
    .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, then settle away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // back-pressure expectations, one entry per cycle after the first accept
  logic       bp_ld   [12] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0};
  logic [7:0] bp_data [12] = '{8'h02,8'h02,8'h02,8'h01,8'h01,8'h01,8'h04,8'h04,8'h04,8'h03,8'h03,8'h03};
  logic       bp_done [12] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
  logic       bp_rdy  [12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1};

  initial begin
    rst_a = 1'b0; in_valid_a = 1'b1; in_word_a = 16'hA55A; in_mode_a = 1'b0;
    rst_b = 1'b0; in_valid_b = 1'b0; in_word_b = 16'h0000; in_mode_b = 1'b0;

    // ---- reset held 3 cycles with in_valid high
    tick(); tick(); tick();
    chk("rst_ld",    16'(ld_a),       16'h0);
    chk("rst_data",  16'(data_a),     16'h00);
    chk("rst_ready", 16'(in_ready_a), 16'h0);
    chk("rst_done",  16'(done_a),     16'h0);
    chk("rst_busy",  16'(busy_a),     16'h0);
    rst_a = 1'b1; rst_b = 1'b1;
    tick();
    chk("rel_ready", 16'(in_ready_a), 16'h1);
    chk("rel_ld",    16'(ld_a),       16'h0);

    // ---- ONE mode, A55A (valid already high)
    tick();  // edge N
    in_valid_a = 1'b0;
    chk("one_ld1",   16'(ld_a),       16'h1);
    chk("one_d1",    16'(data_a),     16'h5A);
    chk("one_busy1", 16'(busy_a),     16'h1);
    chk("one_rdy1",  16'(in_ready_a), 16'h0);
    tick();
    chk("one_done",  16'(done_a),     16'h1);
    chk("one_ld2",   16'(ld_a),       16'h0);
    chk("one_d2",    16'(data_a),     16'h5A);
    tick();
    chk("one_rdy3",  16'(in_ready_a), 16'h1);
    chk("one_done3", 16'(done_a),     16'h0);
    chk("one_ld3",   16'(ld_a),       16'h0);
    chk("one_busy3", 16'(busy_a),     16'h0);

    // ---- TWO mode, GAP=2, 1234
    in_valid_a = 1'b1; in_word_a = 16'h1234; in_mode_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
    chk("two_ld1", 16'(ld_a),   16'h1);
    chk("two_d1",  16'(data_a), 16'h34);
    tick();
    chk("two_ld2", 16'(ld_a),   16'h0);
    chk("two_d2",  16'(data_a), 16'h34);
    chk("two_b2",  16'(busy_a), 16'h1);
    tick();
    chk("two_ld3", 16'(ld_a),   16'h0);
    chk("two_d3",  16'(data_a), 16'h34);
    tick();
    chk("two_ld4", 16'(ld_a),   16'h1);
    chk("two_d4",  16'(data_a), 16'h12);
    tick();
    chk("two_done", 16'(done_a), 16'h1);
    chk("two_ld5",  16'(ld_a),   16'h0);
    chk("two_d5",   16'(data_a), 16'h12);
    tick();
    chk("two_rdy6", 16'(in_ready_a), 16'h1);

    // ---- back-pressure: 0102 then 0304, valid held high
    in_valid_a = 1'b1; in_word_a = 16'h0102; in_mode_a = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) in_word_a = 16'h0304;
      if (i == 6) in_valid_a = 1'b0;
      chk($sformatf("bp_ld%0d", i),   16'(ld_a),       16'(bp_ld[i]));
      chk($sformatf("bp_d%0d", i),    16'(data_a),     16'(bp_data[i]));
      chk($sformatf("bp_done%0d", i), 16'(done_a),     16'(bp_done[i]));
      chk($sformatf("bp_rdy%0d", i),  16'(in_ready_a), 16'(bp_rdy[i]));
    end
    tick();
    chk("bp_nodup", 16'(ld_a), 16'h0);

    // ---- reset during GAP_WAIT of BEEF
    in_valid_a = 1'b1; in_word_a = 16'hBEEF; in_mode_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
    chk("mid_ld1", 16'(ld_a),   16'h1);
    chk("mid_d1",  16'(data_a), 16'hEF);
    tick();
    chk("mid_gap", 16'(ld_a), 16'h0);
    rst_a = 1'b0;
    tick();
    chk("mid_rst_ld",   16'(ld_a),   16'h0);
    chk("mid_rst_data", 16'(data_a), 16'h00);
    chk("mid_rst_busy", 16'(busy_a), 16'h0);
    chk("mid_rst_done", 16'(done_a), 16'h0);
    rst_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mid_post_ld%0d", i),   16'(ld_a),       16'h0);
      chk($sformatf("mid_post_d%0d", i),    16'(data_a),     16'h00);
      chk($sformatf("mid_post_done%0d", i), 16'(done_a),     16'h0);
      chk($sformatf("mid_post_rdy%0d", i),  16'(in_ready_a), 16'h1);
    end
    in_valid_a = 1'b1; in_word_a = 16'h00C3; in_mode_a = 1'b0;
    tick();
    in_valid_a = 1'b0;
    chk("mid_next_ld", 16'(ld_a),   16'h1);
    chk("mid_next_d",  16'(data_a), 16'hC3);
    tick();
    chk("mid_next_done", 16'(done_a), 16'h1);

    // ---- GAP=0 instance, TWO mode, FF00
    chk("g0_rdy0", 16'(in_ready_b), 16'h1);
    in_valid_b = 1'b1; in_word_b = 16'hFF00; in_mode_b = 1'b1;
    tick();
    in_valid_b = 1'b0;
    chk("g0_ld1", 16'(ld_b),   16'h1);
    chk("g0_d1",  16'(data_b), 16'h00);
    tick();
    chk("g0_ld2", 16'(ld_b),   16'h1);
    chk("g0_d2",  16'(data_b), 16'hFF);
    tick();
    chk("g0_done", 16'(done_b), 16'h1);
    chk("g0_ld3",  16'(ld_b),   16'h0);
    chk("g0_d3",   16'(data_b), 16'hFF);
    tick();
    chk("g0_rdy4",  16'(in_ready_b), 16'h1);
    chk("g0_done4", 16'(done_b),     16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
